// File: rtl/s_axil_register_file.sv
// ============================================================================
// s_axil_register_file
//
// AXI4-Lite slave holding NUM_REG 32-bit registers at word offsets 0x00,
// 0x04, ... with byte-strobe writes. Each direction (write, read) allows at
// most one outstanding transaction. Write address and write data are
// captured in independent single-entry holding registers, so they may arrive
// in either order or together. The write commits once both are held and the
// B channel is free (or being freed on the same edge).
//
// Parameters:
//   S_AXI_DATA_WIDTH : data bus width, must be 32 (WSTRB is 4 bits)
//   S_AXI_ADDR_WIDTH : address bus width
//   NUM_REG          : number of registers, power of two, 2..256
//
// Ports:
//   ACLK                 clock, all logic on rising edge
//   ARESET               asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY        write address channel
//   WDATA/WSTRB/WVALID/WREADY     write data channel
//   BRESP/BVALID/BREADY           write response channel
//   ARADDR/ARVALID/ARREADY        read address channel
//   RDATA/RRESP/RVALID/RREADY     read data channel
//
// Build option:
//   AXIL_ADDR_DECERR_EN  when defined, any address >= NUM_REG*4 is out of
//                        range: writes change nothing and return DECERR,
//                        reads return zero data with DECERR. When undefined,
//                        upper address bits are ignored and accesses alias.
// ============================================================================
module s_axil_register_file #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REG          = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [S_AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [S_AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [S_AXI_ADDR_WIDTH-1:0]     ARADDR,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [S_AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY
);

    localparam int IDX_W  = $clog2(NUM_REG);
    localparam int STRB_W = S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Holding-register states for the AW and W channels
    localparam logic [0:0] CH_EMPTY = 1'b0;
    localparam logic [0:0] CH_FULL  = 1'b1;

    // Read path states
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RESP = 1'b1;

    // ------------------------------------------------------------------------
    // Storage and channel state
    // ------------------------------------------------------------------------
    logic [S_AXI_DATA_WIDTH-1:0] r_regs [NUM_REG];

    logic [0:0]                  r_aw_state;
    logic [IDX_W-1:0]            r_aw_idx;
    logic                        r_aw_oor;

    logic [0:0]                  r_w_state;
    logic [S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]           r_wstrb;

    logic                        r_bvalid;
    logic [1:0]                  r_bresp;

    logic [0:0]                  r_rd_state;
    logic [S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                  r_rresp;

    logic                        w_aw_hs;
    logic                        w_w_hs;
    logic                        w_b_hs;
    logic                        w_ar_hs;
    logic                        w_r_hs;
    logic                        w_commit;
    logic [IDX_W-1:0]            w_aw_idx;
    logic [IDX_W-1:0]            w_ar_idx;
    logic                        w_aw_oor;
    logic                        w_ar_oor;

    // Merge new data into an old word, byte lane k taken from data iff strb[k]
    function automatic logic [S_AXI_DATA_WIDTH-1:0] f_merge(
        input logic [S_AXI_DATA_WIDTH-1:0] old_word,
        input logic [S_AXI_DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]           strb
    );
        logic [S_AXI_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign w_aw_idx = AWADDR[2 +: IDX_W];
    assign w_ar_idx = ARADDR[2 +: IDX_W];

`ifdef AXIL_ADDR_DECERR_EN
    assign w_aw_oor = |AWADDR[S_AXI_ADDR_WIDTH-1:IDX_W+2];
    assign w_ar_oor = |ARADDR[S_AXI_ADDR_WIDTH-1:IDX_W+2];
`else
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
`endif

    // Byte-offset bits never matter; upper bits only matter with the option
    logic w_unused_addr;
    assign w_unused_addr = ^{AWADDR[1:0], ARADDR[1:0],
                             AWADDR[S_AXI_ADDR_WIDTH-1:IDX_W+2],
                             ARADDR[S_AXI_ADDR_WIDTH-1:IDX_W+2]};

    // ------------------------------------------------------------------------
    // Handshakes. READY outputs are gated by ARESET so they drop the moment
    // reset asserts and rise in the first cycle after release.
    // ------------------------------------------------------------------------
    assign AWREADY = ARESET && (r_aw_state == CH_EMPTY);
    assign WREADY  = ARESET && (r_w_state  == CH_EMPTY);
    assign ARREADY = ARESET && (r_rd_state == RD_IDLE);

    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign RVALID  = (r_rd_state == RD_RESP);
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID  && WREADY;
    assign w_b_hs  = r_bvalid && BREADY;
    assign w_ar_hs = ARVALID && ARREADY;
    assign w_r_hs  = RVALID  && RREADY;

    // Commit only from already-registered AW and W; a response still held
    // on B blocks it unless that response is being accepted this edge.
    assign w_commit = (r_aw_state == CH_FULL) && (r_w_state == CH_FULL) &&
                      (!r_bvalid || BREADY);

    // ------------------------------------------------------------------------
    // AW holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_aw_state <= CH_EMPTY;
            r_aw_idx   <= '0;
            r_aw_oor   <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_state <= CH_FULL;
            r_aw_idx   <= w_aw_idx;
            r_aw_oor   <= w_aw_oor;
        end else if (w_commit) begin
            r_aw_state <= CH_EMPTY;
        end
    end

    // ------------------------------------------------------------------------
    // W holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_w_state <= CH_EMPTY;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_w_hs) begin
            r_w_state <= CH_FULL;
            r_wdata   <= WDATA;
            r_wstrb   <= WSTRB;
        end else if (w_commit) begin
            r_w_state <= CH_EMPTY;
        end
    end

    // ------------------------------------------------------------------------
    // Register array update
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            for (int i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !r_aw_oor) begin
            r_regs[r_aw_idx] <= f_merge(r_regs[r_aw_idx], r_wdata, r_wstrb);
        end
    end

    // ------------------------------------------------------------------------
    // Write response. A commit on the same edge as a B handshake re-arms
    // BVALID, giving back-to-back responses.
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_oor ? RESP_DECERR : RESP_OKAY;
        end else if (w_b_hs) begin
            r_bvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Read path. The array is sampled with its pre-edge contents, so a read
    // colliding with a commit to the same register returns the old value.
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_rd_state <= RD_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rd_state <= RD_RESP;
            r_rdata    <= w_ar_oor ? '0 : r_regs[w_ar_idx];
            r_rresp    <= w_ar_oor ? RESP_DECERR : RESP_OKAY;
        end else if (w_r_hs) begin
            r_rd_state <= RD_IDLE;
        end
    end

endmodule

// File: tb/tb_s_axil_register_file.sv
module tb_s_axil_register_file;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b1;

    s_axil_register_file #(
        .S_AXI_DATA_WIDTH(32),
        .S_AXI_ADDR_WIDTH(32),
        .NUM_REG(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain array of words, updated in transaction order
    logic [31:0] mem [16];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    function automatic bit is_oor(input logic [31:0] a);
`ifdef AXIL_ADDR_DECERR_EN
        return a >= 32'd64;
`else
        return a >= 32'd64 && 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return is_oor(a) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [33:0] exp_read(input logic [31:0] a);
        logic [31:0] d;
        d = is_oor(a) ? 32'h0 : mem[idx_of(a)];
        return {d, exp_resp(a)};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!is_oor(a)) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) mem[idx_of(a)][8*k +: 8] = d[8*k +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic aw_send(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        AWADDR = a; AWVALID = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge ACLK); ok = AWREADY;
            @(posedge ACLK); #1;
        end
        AWVALID = 1'b0;
        if (!ok) note_timeout("aw_handshake");
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge ACLK); ok = WREADY;
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        if (!ok) note_timeout("w_handshake");
    endtask

    task automatic ar_send(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        ARADDR = a; ARVALID = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge ACLK); ok = ARREADY;
            @(posedge ACLK); #1;
        end
        ARVALID = 1'b0;
        if (!ok) note_timeout("ar_handshake");
    endtask

    // rdy < 0: raise BREADY only once BVALID is seen; otherwise after rdy cycles
    task automatic wait_b(input int rdy);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if ((rdy < 0) ? BVALID : (c >= rdy)) BREADY = 1'b1;
            @(negedge ACLK);
            if (BVALID && BREADY) done = 1'b1;
            @(posedge ACLK); #1;
        end
        if (!done) note_timeout("b_handshake");
    endtask

    task automatic wait_r(input int rdy);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if ((rdy < 0) ? RVALID : (c >= rdy)) RREADY = 1'b1;
            @(negedge ACLK);
            if (RVALID && RREADY) done = 1'b1;
            @(posedge ACLK); #1;
        end
        if (!done) note_timeout("r_handshake");
    endtask

    task automatic write_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input int awd, input int wd);
        b_q.push_back(exp_resp(a));
        fork
            begin repeat (awd) begin @(posedge ACLK); #1; end aw_send(a); end
            begin repeat (wd)  begin @(posedge ACLK); #1; end w_send(d, s); end
        join
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, input int rdy);
        BREADY = (rdy == 0);
        write_issue(a, d, s, awd, wd);
        model_write(a, d, s);
        wait_b(rdy);
    endtask

    task automatic axi_read(input logic [31:0] a, input int rdy);
        r_q.push_back(exp_read(a));
        RREADY = (rdy == 0);
        ar_send(a);
        wait_r(rdy);
    endtask

    // --------------------------------------------------------------- monitors
    logic       b_hold = 1'b0;
    logic [1:0] b_hold_resp = '0;
    logic [1:0] b_exp;
    always @(negedge ACLK) begin
        if (!ARESET) begin
            b_hold = 1'b0;
        end else begin
            if (b_hold) begin
                chk("b_valid_hold", 32'(BVALID), 32'd1);
                chk("b_resp_stable", 32'(BRESP), 32'(b_hold_resp));
            end
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    note_timeout("unexpected_b_response");
                end else begin
                    b_exp = b_q.pop_front();
                    chk("bresp", 32'(BRESP), 32'(b_exp));
                end
            end
            b_hold = BVALID && !BREADY;
            b_hold_resp = BRESP;
        end
    end

    logic        r_hold = 1'b0;
    logic [33:0] r_hold_val = '0;
    logic [33:0] r_exp;
    always @(negedge ACLK) begin
        if (!ARESET) begin
            r_hold = 1'b0;
        end else begin
            if (r_hold) begin
                chk("r_valid_hold", 32'(RVALID), 32'd1);
                chk("r_data_stable", RDATA, r_hold_val[33:2]);
                chk("r_resp_stable", 32'(RRESP), 32'(r_hold_val[1:0]));
            end
            if (RVALID && RREADY) begin
                if (r_q.size() == 0) begin
                    note_timeout("unexpected_r_response");
                end else begin
                    r_exp = r_q.pop_front();
                    chk("rdata", RDATA, r_exp[33:2]);
                    chk("rresp", 32'(RRESP), 32'(r_exp[1:0]));
                end
            end
            r_hold = RVALID && !RREADY;
            r_hold_val = {RDATA, RRESP};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        model_clear();
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_wready",  32'(WREADY),  32'd0);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_bvalid",  32'(BVALID),  32'd0);
        chk("rst_rvalid",  32'(RVALID),  32'd0);
        chk("rst_bresp",   32'(BRESP),   32'd0);
        chk("rst_rresp",   32'(RRESP),   32'd0);
        chk("rst_rdata",   RDATA,        32'd0);
        ARESET = 1'b1;
        #1;
        chk("post_rst_awready", 32'(AWREADY), 32'd1);
        chk("post_rst_wready",  32'(WREADY),  32'd1);
        chk("post_rst_arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;

        // 1: fill all registers, AW leading W by one cycle, BREADY after BVALID
        for (int i = 0; i < 16; i++) axi_write(32'(4 * i), 32'(i + 1), 4'hF, 0, 1, -1);
        for (int i = 0; i < 16; i++) axi_read(32'(4 * i), 0);

        // 2: byte strobes
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(32'h08, 32'h1234_5678, 4'b0101, 0, 0, 0);
        axi_read(32'h08, 0);
        axi_write(32'h08, 32'hDEAD_BEEF, 4'b0000, 1, 0, 0);
        axi_read(32'h08, 0);

        // 3: W before AW, B held off, second write blocked behind it
        BREADY = 1'b0;
        b_q.push_back(exp_resp(32'h20));
        fork
            begin
                w_send(32'h1111_1111, 4'hF);
                chk("w_ready_after_w", 32'(WREADY), 32'd0);
            end
            begin
                repeat (3) begin @(posedge ACLK); #1; end
                aw_send(32'h20);
                chk("aw_ready_after_aw", 32'(AWREADY), 32'd0);
            end
        join
        model_write(32'h20, 32'h1111_1111, 4'hF);
        repeat (2) begin @(posedge ACLK); #1; end
        chk("b_valid_held", 32'(BVALID), 32'd1);
        write_issue(32'h20, 32'h2222_2222, 4'hF, 0, 0);
        repeat (2) begin @(posedge ACLK); #1; end
        chk("aw_ready_blocked", 32'(AWREADY), 32'd0);
        chk("w_ready_blocked",  32'(WREADY),  32'd0);
        axi_read(32'h20, 0);
        repeat (2) begin @(posedge ACLK); #1; end
        model_write(32'h20, 32'h2222_2222, 4'hF);
        wait_b(0);
        repeat (3) begin @(posedge ACLK); #1; end
        axi_read(32'h20, 0);

        // 4: read colliding with a commit to the same register
        BREADY = 1'b1; RREADY = 1'b1;
        r_q.push_back(exp_read(32'h0C));
        fork
            write_issue(32'h0C, 32'h0000_00A5, 4'hF, 0, 0);
            begin @(posedge ACLK); #1; ar_send(32'h0C); end
        join
        model_write(32'h0C, 32'h0000_00A5, 4'hF);
        repeat (3) begin @(posedge ACLK); #1; end
        axi_read(32'h0C, 0);

        // 6: address beyond the register range
        axi_write(32'h40, 32'h0000_0055, 4'hF, 0, 0, 0);
        axi_read(32'h40, 0);
        axi_read(32'h00, 0);

        // Randomized mixed traffic
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 4)) - 1);
            end else begin
                axi_read(a, int'($urandom_range(0, 4)) - 1);
            end
        end

        // 5: reset with both responses pending
        BREADY = 1'b0; RREADY = 1'b0;
        write_issue(32'h04, 32'hCAFE_F00D, 4'hF, 0, 0);
        r_q.push_back(exp_read(32'h10));
        ar_send(32'h10);
        repeat (2) begin @(posedge ACLK); #1; end
        chk("pre_rst_bvalid", 32'(BVALID), 32'd1);
        chk("pre_rst_rvalid", 32'(RVALID), 32'd1);
        #2 ARESET = 1'b0;
        #1;
        chk("rst2_awready", 32'(AWREADY), 32'd0);
        chk("rst2_wready",  32'(WREADY),  32'd0);
        chk("rst2_arready", 32'(ARREADY), 32'd0);
        chk("rst2_bvalid",  32'(BVALID),  32'd0);
        chk("rst2_rvalid",  32'(RVALID),  32'd0);
        chk("rst2_rdata",   RDATA,        32'd0);
        b_q.delete();
        r_q.delete();
        model_clear();
        BREADY = 1'b1; RREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b1;
        #1;
        chk("rst2_rel_awready", 32'(AWREADY), 32'd1);
        chk("rst2_rel_arready", 32'(ARREADY), 32'd1);
        repeat (5) begin @(posedge ACLK); #1; end
        for (int i = 0; i < 16; i++) axi_read(32'(4 * i), 0);

        repeat (4) begin @(posedge ACLK); #1; end
        chk("b_queue_drained", 32'(b_q.size()), 32'd0);
        chk("r_queue_drained", 32'(r_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/s_axil_register_file.md
Name: s_axil_register_file

Overview:
AXI4-Lite slave register file that sits directly downstream of the AXI-Lite master BFM and serves its write and read traffic. It holds NUM_REG word-wide registers at word-aligned offsets 0x00, 0x04, ... and supports byte strobes. The AW, W, B, AR and R channels are fully handshaked. Each direction has at most one outstanding transaction.

Parameters:
S_AXI_DATA_WIDTH, 32, data bus width; must be 32 (WSTRB is 4 bits)
S_AXI_ADDR_WIDTH, 32, address bus width
NUM_REG, 16, number of registers; power of two, 2..256

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESET  input  1  asynchronous active-low reset
AWADDR  input  S_AXI_ADDR_WIDTH  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  S_AXI_DATA_WIDTH  write data
WSTRB  input  S_AXI_DATA_WIDTH/8  byte strobes
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BRESP  output  2  write response
BVALID  output  1  write response valid
BREADY  input  1  write response ready
ARADDR  input  S_AXI_ADDR_WIDTH  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  S_AXI_DATA_WIDTH  read data
RRESP  output  2  read response
RVALID  output  1  read data valid
RREADY  input  1  read data ready

Behaviour:
- Reset (ARESET=0, async assert, sync-release safe):
  - all registers = 0
  - AWREADY=WREADY=ARREADY=0 during reset
  - BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0
  - AW/W holding flags cleared; in-flight transactions dropped with no response
- First cycle out of reset: AWREADY=WREADY=ARREADY=1.
- Decode: index = ADDR[2 +: log2(NUM_REG)]. ADDR[1:0] are ignored. Higher bits are ignored (aliasing) unless the optional feature is compiled in.
- Write path, state per channel, EMPTY/FULL:
  - AW holding register: AWREADY = !aw_full. Handshake latches AWADDR and sets aw_full.
  - W holding register: WREADY = !w_full. Handshake latches WDATA/WSTRB and sets w_full.
  - AW and W may arrive in either order, same cycle, or any number of cycles apart.
  - Commit condition: aw_full && w_full && (!BVALID || BREADY), both registered flags already set.
  - On commit, at the next edge:
    - write byte k of reg[index] iff WSTRB[k]
    - BVALID=1, BRESP=2'b00
    - clear aw_full and w_full
  - Latency: both handshakes at edge N -> register updated and BVALID high at edge N+1.
  - BVALID holds, with BRESP stable, until a BVALID&&BREADY edge. A new commit may occur on that same edge (back-to-back).
  - WSTRB=0: no bytes change, OKAY response still issued.
- Read path, states IDLE/RESP:
  - ARREADY = !RVALID.
  - AR handshake at edge N -> RDATA = reg[index], RRESP=2'b00, RVALID=1 at edge N+1.
  - RVALID/RDATA/RRESP hold stable until an RVALID&&RREADY edge, then RVALID=0 and ARREADY=1 on the following cycle.
- Read/write collision: if a read samples a register on the same edge that a write commits to it, RDATA returns the old value.
- Read and write paths are independent and may proceed concurrently.

Optional Feature:
AXIL_ADDR_DECERR_EN
- Defined: any access with ADDR >= NUM_REG*4 is out of range.
  - Write: no register changes; BRESP=2'b11 (DECERR).
  - Read: RDATA=0, RRESP=2'b11.
  - Handshake timing is unchanged.
- Undefined: upper address bits are ignored. Out-of-range accesses alias onto reg[index] and respond OKAY.

Test Plan:
1. Reset, then write data i+1 to addr 4*i for i=0..15 (AW one cycle before W, BREADY after BVALID), then read all 16 -> RDATA = 1..16, every BRESP/RRESP=0.
2. Write 0xFFFFFFFF to 0x08, then write 0x12345678 with WSTRB=4'b0101 -> read 0x08 returns 0xFF34FF78.
3. W before AW by 3 cycles; BREADY held low 5 cycles -> WREADY low after W accepted; AWREADY low after AW accepted; BVALID stays high, BRESP stable, second write not committed until B handshake.
4. AR to 0x0C on the same edge a write of 0xA5 to 0x0C commits (old value 0x4) -> RDATA=0x4; next read returns 0xA5.
5. Assert ARESET low while BVALID=1 and RVALID=1 -> all VALID/READY=0 immediately; after release all registers read 0 and no stale B/R appears.
6. Write 0x55 to 0x40 and read 0x40 -> without macro, reg[0]=0x55 and read 0x40 returns 0x55 with OKAY; with AXIL_ADDR_DECERR_EN, BRESP=RRESP=2'b11, RDATA=0, reg[0] unchanged.
